// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: ordered bring-up and tear-down of N_STAGE active-low reset domains
module rst_seq_ctrl #(
   parameter int N_STAGE = 4,
   parameter int GAP     = 16,
   parameter int TIMEOUT = 256,
   parameter int CNT_W   = 12
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_en,
   input  logic               i_sw_rst,
   input  logic [N_STAGE-1:0] i_ack,
   output logic [N_STAGE-1:0] o_rstn,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_err,
   output logic [2:0]         o_stage
);

   typedef enum logic [2:0] {IDLE, GAP_WAIT, ACK_WAIT, RUN, DOWN, ERROR} state_t;

   state_t             state, state_nxt;
   logic [2:0]         idx, idx_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [N_STAGE-1:0] rstn_nxt, sel;
   logic               busy_nxt, done_nxt, err_nxt;
   logic               abort, ack_hit, last;

   assign sel     = N_STAGE'(1) << idx;
   assign ack_hit = |(i_ack & sel);
   assign last    = idx == 3'(N_STAGE - 1);
   assign abort   = !i_en || i_sw_rst;
   assign o_stage = idx;

   // state and registered outputs, cleared synchronously by i_rst
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= IDLE;
         idx    <= '0;
         cnt    <= '0;
         o_rstn <= '0;
         o_busy <= 1'b0;
         o_done <= 1'b0;
         o_err  <= 1'b0;
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         cnt    <= cnt_nxt;
         o_rstn <= rstn_nxt;
         o_busy <= busy_nxt;
         o_done <= done_nxt;
         o_err  <= err_nxt;
      end
   end

   // sequencing decisions; an ack beats a timeout expiring on the same cycle
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      rstn_nxt  = o_rstn;
      busy_nxt  = o_busy;
      done_nxt  = o_done;
      err_nxt   = o_err;
      case (state)
         IDLE: begin
            if (i_en) begin
               state_nxt = GAP_WAIT;
               idx_nxt   = '0;
               cnt_nxt   = '0;
               busy_nxt  = 1'b1;
            end
         end
         GAP_WAIT: begin
            if (abort) begin
               state_nxt = DOWN;
               cnt_nxt   = '0;
            end else if (cnt == CNT_W'(GAP - 1)) begin
               rstn_nxt  = o_rstn | sel;
               cnt_nxt   = '0;
               state_nxt = ACK_WAIT;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ACK_WAIT: begin
            if (abort) begin
               state_nxt = DOWN;
               cnt_nxt   = '0;
            end else if (ack_hit) begin
               state_nxt = last ? RUN : GAP_WAIT;
               idx_nxt   = last ? idx : idx + 1'b1;
               cnt_nxt   = '0;
               done_nxt  = last;
               busy_nxt  = !last;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               state_nxt = ERROR;
               rstn_nxt  = '0;
               err_nxt   = 1'b1;
               busy_nxt  = 1'b0;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         RUN: begin
            if (abort) begin
               state_nxt = DOWN;
               idx_nxt   = 3'(N_STAGE - 1);
               done_nxt  = 1'b0;
               busy_nxt  = 1'b1;
            end
         end
         DOWN: begin
            rstn_nxt  = o_rstn & ~sel;
            state_nxt = (idx == '0) ? IDLE : DOWN;
            idx_nxt   = (idx == '0) ? idx : idx - 1'b1;
            busy_nxt  = idx != '0;
         end
         ERROR: begin
            if (abort) begin
               state_nxt = IDLE;
               err_nxt   = 1'b0;
               idx_nxt   = '0;
               cnt_nxt   = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
